// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow clock clk_in, counted in clk cycles.
// state | meaning
// IDLE  | measurement disabled, waiting for meas_en
// ARM   | waiting for the tick that starts a period
// MEAS  | counting cycles (and high cycles) until the next tick
// HOLD  | result presented on period/high_time until valid&&ready
module clk_period_meter #(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 200_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             meas_en,
  input  logic             ready,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   seen_low_q, seen_low_d;
  logic                   lvl_q, lvl_d;
  logic                   tick_q, tick_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   en_q, en_d;
  logic                   sync_lvl;
  logic                   sync_real;
  logic                   timeout_hit;

  // fill_q marks when the synchronizer output carries a real sample rather than
  // its reset zero; a tick needs a real low first, so a clk_in already high at
  // reset release never produces one.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], clk_in};
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sync_lvl   = sync_q[SYNC_STAGES-1];
    sync_real  = fill_q[SYNC_STAGES-1];
    seen_low_d = seen_low_q | (sync_real & ~sync_lvl);
    lvl_d      = sync_lvl;
    tick_d     = sync_lvl & ~lvl_q & seen_low_q;
  end

  assign timeout_hit = (64'(cnt_q) == 64'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    en_d      = meas_en;

    if (meas_en && !en_q) timeout_d = 1'b0;

    if (!meas_en) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (tick_q) begin
            state_d = S_MEAS;
            cnt_d   = CNT_ONE;
            hcnt_d  = lvl_q ? CNT_ONE : '0;
          end
        end
        S_MEAS: begin
          // a tick on the timeout cycle still completes the measurement
          if (tick_q) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end else if (timeout_hit) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
            state_d   = S_ARM;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            if (lvl_q && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (ready) begin
            valid_d = 1'b0;
            state_d = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      fill_q     <= '0;
      seen_low_q <= 1'b0;
      lvl_q      <= 1'b0;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      fill_q     <= fill_d;
      seen_low_q <= seen_low_d;
      lvl_q      <= lvl_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      en_q       <= en_d;
    end
  end

  assign tick      = tick_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized clk_in/enable/ready.
module tb_clk_period_meter;
  localparam int N    = 2;
  localparam int W    = 32;
  localparam int TO   = 100;
  localparam int MAXE = 20000;
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_HOLD = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_in = 1'b1;
  logic         meas_en = 1'b0;
  logic         ready = 1'b0;
  logic         tick, valid, timeout;
  logic [W-1:0] period, high_time;

  clk_period_meter #(.SYNC_STAGES(N), .CNT_W(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_in   (clk_in),
    .meas_en  (meas_en),
    .tick     (tick),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .ready    (ready),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Cycle e = interval after the e-th clk edge since reset
  // release. The synchronized level in cycle e is the clk_in sample taken N
  // edges earlier; a tick is a 0->1 step of that level between real samples.
  // Measurements are kept as timestamps: period = tick time difference,
  // high time = sum of levels over the measured window.
  bit smp_a [MAXE];
  bit lv_a  [MAXE];
  int e = 0;
  int m_mode = M_IDLE;
  int t_start = 0;
  bit m_tick = 1'b0;
  bit m_lvl = 1'b0;
  bit en_last = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_timeout = 1'b0;
  int exp_period = 0;
  int exp_high = 0;

  task automatic model_reset();
    e = 0; m_mode = M_IDLE; t_start = 0; m_tick = 0; m_lvl = 0; en_last = 0;
    exp_valid = 0; exp_timeout = 0; exp_period = 0; exp_high = 0;
  endtask

  task automatic model_step();
    bit tk;
    int s;
    tk = m_tick;
    smp_a[e] = clk_in;
    if (meas_en && !en_last) exp_timeout = 0;
    en_last = meas_en;
    if (!meas_en) begin
      m_mode = M_IDLE;
      exp_valid = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_ARM;
        M_ARM: if (tk) begin m_mode = M_MEAS; t_start = e - 1; end
        M_MEAS: begin
          if (tk) begin
            s = 0;
            for (int k = t_start; k <= e - 2; k++) s += int'(lv_a[k]);
            exp_period = e - 1 - t_start;
            exp_high = s;
            exp_valid = 1;
            m_mode = M_HOLD;
          end else if (e - 1 - t_start == TO) begin
            exp_timeout = 1;
            m_mode = M_ARM;
          end
        end
        default: if (ready) begin exp_valid = 0; m_mode = M_ARM; end
      endcase
    end
    m_lvl = (e >= N) ? smp_a[e-N] : 1'b0;
    lv_a[e] = m_lvl;
    m_tick = (e >= N + 1) && smp_a[e-N] && !smp_a[e-N-1];
    e++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else if (e >= MAXE - 1) begin
      $display("FAIL model_capacity: dut=%0d expected=%0d", e, MAXE - 1);
      $fatal(1, "model history exhausted");
    end else model_step();
  end

  // Per-cycle comparison against the model.
  int dut_ticks = 0;
  initial forever begin
    @(negedge clk);
    if (tick) dut_ticks++;
    chk("cyc_tick",      W'(tick),    W'(m_tick));
    chk("cyc_valid",     W'(valid),   W'(exp_valid));
    chk("cyc_timeout",   W'(timeout), W'(exp_timeout));
    chk("cyc_period",    period,      W'(exp_period));
    chk("cyc_high_time", high_time,   W'(exp_high));
  end

  // clk_in generator: 0 low, 1 high, 2 periodic pattern, 3 random runs.
  int gen_mode = 1;
  int gen_p = 10, gen_h = 5, gen_ph = 0;
  int run_left = 0;
  bit rnd_lvl = 1'b0;
  initial forever begin
    bit nxt;
    @(negedge clk);
    nxt = clk_in;
    case (gen_mode)
      0: nxt = 1'b0;
      1: nxt = 1'b1;
      2: begin
        nxt = (gen_ph < gen_h);
        gen_ph = (gen_ph + 1 == gen_p) ? 0 : gen_ph + 1;
      end
      default: begin
        if (run_left == 0) begin
          rnd_lvl = ~rnd_lvl;
          run_left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(90, 130))
                                                  : int'($urandom_range(1, 15));
        end
        run_left--;
        nxt = rnd_lvl;
      end
    endcase
    clk_in = nxt;
  end

  task automatic start_pattern(input int p, input int h);
    gen_p = p; gen_h = h; gen_ph = 0; gen_mode = 2;
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, W'(valid), 1);
  endtask

  initial begin
    int lastp, lasth, nval;

    // reset with clk_in high
    repeat (3) @(negedge clk);
    chk("rst_tick", W'(tick), 0);
    chk("rst_valid", W'(valid), 0);
    chk("rst_timeout", W'(timeout), 0);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    rst_n = 1'b1;
    dut_ticks = 0;
    repeat (20) @(negedge clk);
    chk("no_tick_from_high_at_release", dut_ticks, 0);

    // 10-cycle period, 50% duty
    gen_mode = 0;
    repeat (6) @(negedge clk);
    meas_en = 1'b1;
    ready = 1'b1;
    start_pattern(10, 5);
    wait_valid(80, "p10_valid_seen");
    chk("p10_period", period, 10);
    chk("p10_high_time", high_time, 5);
    nval = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid) nval++;
    end
    chk("p10_results_every_2nd_period", nval, 5);

    // 7-cycle period, 2 high; tick count equals rising-edge count
    gen_mode = 0;
    repeat (12) @(negedge clk);
    dut_ticks = 0;
    lastp = 0;
    lasth = 0;
    start_pattern(7, 2);
    repeat (68) begin
      @(negedge clk);
      if (valid) begin lastp = period; lasth = high_time; end
    end
    gen_mode = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid) begin lastp = period; lasth = high_time; end
    end
    chk("p7_tick_count", dut_ticks, 10);
    chk("p7_period", lastp, 7);
    chk("p7_high_time", lasth, 2);

    // timeout after a single arming edge
    meas_en = 1'b0;
    repeat (3) @(negedge clk);
    meas_en = 1'b1;
    repeat (3) @(negedge clk);
    gen_mode = 1;
    repeat (3) @(negedge clk);
    gen_mode = 0;
    repeat (130) @(negedge clk);
    chk("to_flag_set", W'(timeout), 1);
    chk("to_no_result", W'(valid), 0);
    meas_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("to_sticky_while_disabled", W'(timeout), 1);
    meas_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("to_cleared_on_enable", W'(timeout), 0);

    // back-pressure: result held while clk_in keeps toggling
    ready = 1'b0;
    start_pattern(10, 5);
    wait_valid(80, "hold_valid_seen");
    repeat (50) begin
      @(negedge clk);
      chk("hold_valid_stays", W'(valid), 1);
      chk("hold_period_stable", period, 10);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid_low", W'(valid), 0);

    // disable mid-measurement
    wait_valid(80, "drop_valid_seen");
    repeat (13) @(negedge clk);
    meas_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_valid_low", W'(valid), 0);
    chk("drop_period_kept", period, 10);
    meas_en = 1'b1;

    // asynchronous reset during a measurement while clk_in is high
    start_pattern(20, 10);
    repeat (45) @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      #1;
      if (clk_in) break;
    end
    #2;
    rst_n = 1'b0;
    gen_mode = 1;
    #1;
    chk("async_rst_tick", W'(tick), 0);
    chk("async_rst_valid", W'(valid), 0);
    chk("async_rst_timeout", W'(timeout), 0);
    chk("async_rst_period", period, 0);
    chk("async_rst_high_time", high_time, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dut_ticks = 0;
    repeat (15) @(negedge clk);
    chk("no_tick_until_low_then_high", dut_ticks, 0);
    start_pattern(10, 5);
    wait_valid(80, "post_rst_valid_seen");
    chk("post_rst_period", period, 10);

    // randomized clk_in, ready and occasional enable toggles
    gen_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) meas_en = ~meas_en;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
